// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default bit timing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // 12 MHz core clock at 115200 baud. A future transmitter uses the same value.
  localparam int UART_CLKS_PER_BIT = 104;

  typedef enum logic [2:0] {
    UART_IDLE      = 3'd0,
    UART_START     = 3'd1,
    UART_DATA      = 3'd2,
    UART_STOP      = 3'd3,
    UART_WAIT_IDLE = 3'd4
  } uart_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; d is sampled every cycle.
// Ports: clk, reset (sync, active-high; both stages load RESET_VAL),
//        d (asynchronous input), q (synchronized output).
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: resynchronizes rx, rejects start glitches, flags bad stop bits.
// Latency: received/recv_error pulse one cycle after the mid-stop-bit sample.
// Backpressure: none; consumer must take rx_byte before the next frame completes.
// Ports: clk, reset (sync, active-high), rx (async serial line, idles high),
//        received (1-cycle pulse, valid frame), rx_byte (last good byte),
//        recv_error (1-cycle pulse, stop bit low), is_receiving (START/DATA/STOP).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       received,
  output logic [7:0] rx_byte,
  output logic       recv_error,
  output logic       is_receiving
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

  logic rx_sync;

  uart_state_e      state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [2:0]       bit_idx_q,    bit_idx_d;
  logic [7:0]       shreg_q,      shreg_d;
  logic [7:0]       rx_byte_q,    rx_byte_d;
  logic             received_q,   received_d;
  logic             recv_error_q, recv_error_d;
  logic [1:0]       flush_q,      flush_d;
  logic             sync_live;

  sync2 #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_sync)
  );

  // The synchronizer outputs its reset value (high) for two cycles after
  // reset, which would look like an idle line even when rx is stuck low.
  // WAIT_IDLE only trusts rx_sync once those stale values have drained.
  assign flush_d   = {flush_q[0], 1'b1};
  assign sync_live = flush_q[1];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    rx_byte_d    = rx_byte_q;
    received_d   = 1'b0;
    recv_error_d = 1'b0;

    case (state_q)
      UART_IDLE: begin
        if (!rx_sync) begin
          state_d = UART_START;
          cnt_d   = '0;
        end
      end

      // Re-check the line at the middle of the start bit; a high line there
      // means the falling edge was noise.
      UART_START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_HALF_M1) begin
          if (!rx_sync) begin
            state_d   = UART_DATA;
            cnt_d     = '0;
            bit_idx_d = 3'd0;
          end else begin
            state_d = UART_IDLE;
          end
        end
      end

      // Sample point is now mid-bit; shift LSB first.
      UART_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_BIT_M1) begin
          shreg_d = {rx_sync, shreg_q[7:1]};
          cnt_d   = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = UART_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      // Returning to IDLE right at the stop sample lets a back-to-back start
      // edge be caught during the second half of the stop bit.
      UART_STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_BIT_M1) begin
          cnt_d = '0;
          if (rx_sync) begin
            rx_byte_d  = shreg_q;
            received_d = 1'b1;
            state_d    = UART_IDLE;
          end else begin
            recv_error_d = 1'b1;
            state_d      = UART_WAIT_IDLE;
          end
        end
      end

      UART_WAIT_IDLE: begin
        if (rx_sync && sync_live) begin
          state_d = UART_IDLE;
        end
      end

      default: begin
        state_d = UART_WAIT_IDLE;
      end
    endcase
  end

  // Reset parks in WAIT_IDLE so a line held low never starts a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= UART_WAIT_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shreg_q      <= 8'h00;
      rx_byte_q    <= 8'h00;
      received_q   <= 1'b0;
      recv_error_q <= 1'b0;
      flush_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      rx_byte_q    <= rx_byte_d;
      received_q   <= received_d;
      recv_error_q <= recv_error_d;
      flush_q      <= flush_d;
    end
  end

  assign received     = received_q;
  assign recv_error   = recv_error_q;
  assign rx_byte      = rx_byte_q;
  assign is_receiving = (state_q == UART_START) ||
                        (state_q == UART_DATA)  ||
                        (state_q == UART_STOP);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CPB  = 4;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       received;
  logic [7:0] rx_byte;
  logic       recv_error;
  logic       is_receiving;

  always #5 clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .received     (received),
    .rx_byte      (rx_byte),
    .recv_error   (recv_error),
    .is_receiving (is_receiving)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- observation of the DUT ----------------
  int   rcv_cyc_q[$];
  logic [7:0] rcv_byte_q[$];
  int   err_cyc_q[$];
  int   busy_total = 0;

  always @(negedge clk) begin
    if (received === 1'b1) begin
      rcv_cyc_q.push_back(cyc);
      rcv_byte_q.push_back(rx_byte);
    end
    if (recv_error === 1'b1) err_cyc_q.push_back(cyc);
    if (is_receiving === 1'b1) busy_total <= busy_total + 1;
  end

  // ---------------- reference model ----------------
  // Line as the receiver sees it: rx delayed two clocks, high while in reset.
  logic m_s1, m_s2;
  always @(posedge clk) begin
    if (reset) begin
      m_s1 <= 1'b1;
      m_s2 <= 1'b1;
    end else begin
      m_s1 <= rx;
      m_s2 <= m_s1;
    end
  end

  logic       exp_rcv    = 1'b0;
  logic       exp_err    = 1'b0;
  logic       exp_busy   = 1'b0;
  logic [7:0] exp_byte   = 8'h00;
  bit         model_live = 1'b0;
  int         since_rst  = 0;

  // Move to the next cycle; report whether reset was taken at that edge.
  task automatic adv(output bit r);
    @(posedge clk);
    r = reset;
    #1;
    exp_rcv = 1'b0;
    exp_err = 1'b0;
    if (r) begin
      model_live = 1'b1;
      since_rst  = 0;
      exp_byte   = 8'h00;
      exp_busy   = 1'b0;
    end else begin
      since_rst++;
    end
  endtask

  // Called in the first idle cycle that sees the line low (T0). Returns in
  // the cycle after the frame ends, with that cycle's outputs predicted.
  task automatic run_frame(output bit r, output bit werr);
    logic [7:0] d;
    logic       stop;
    werr = 1'b0;
    for (int i = 0; i < HALF; i++) begin
      adv(r);
      if (r) return;
      exp_busy = 1'b1;
    end
    if (m_s2) begin
      adv(r);
      if (r) return;
      exp_busy = 1'b0;
      return;
    end
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < CPB; i++) begin
        adv(r);
        if (r) return;
        exp_busy = 1'b1;
      end
      d[k] = m_s2;
    end
    for (int i = 0; i < CPB; i++) begin
      adv(r);
      if (r) return;
      exp_busy = 1'b1;
    end
    stop = m_s2;
    adv(r);
    if (r) return;
    exp_busy = 1'b0;
    if (stop) begin
      exp_rcv  = 1'b1;
      exp_byte = d;
    end else begin
      exp_err = 1'b1;
      werr    = 1'b1;
    end
  endtask

  initial begin : model
    bit r;
    bit werr;
    bit need_high;
    need_high = 1'b1;
    adv(r);
    forever begin
      if (need_high) begin
        // After reset or a framing error: wait for a genuinely high line,
        // ignoring the synchronizer's reset value.
        if (since_rst >= 2 && m_s2 === 1'b1) need_high = 1'b0;
        adv(r);
        if (r) need_high = 1'b1;
      end else if (m_s2 !== 1'b0) begin
        adv(r);
        if (r) need_high = 1'b1;
      end else begin
        run_frame(r, werr);
        if (r || werr) need_high = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("cmp_received",     {31'd0, received},     {31'd0, exp_rcv});
      check("cmp_recv_error",   {31'd0, recv_error},   {31'd0, exp_err});
      check("cmp_is_receiving", {31'd0, is_receiving}, {31'd0, exp_busy});
      check("cmp_rx_byte",      {24'd0, rx_byte},      {24'd0, exp_byte});
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int start_cyc);
    start_cyc = cyc;
    rx = 1'b0;
    idle(CPB);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      idle(CPB);
    end
    rx = stop;
    idle(CPB);
  endtask

  initial begin : stim
    int s, s2, n0, e0, b0;
    logic [7:0] v;

    // Reset state
    reset = 1'b1;
    rx    = 1'b1;
    idle(3);
    check("reset_received",     {31'd0, received},     32'd0);
    check("reset_rx_byte",      {24'd0, rx_byte},      32'h00);
    check("reset_recv_error",   {31'd0, recv_error},   32'd0);
    check("reset_is_receiving", {31'd0, is_receiving}, 32'd0);
    reset = 1'b0;
    idle(6);

    // 0xA5: pulse 41 cycles after the falling edge is driven (T0 = edge+2)
    n0 = rcv_cyc_q.size(); e0 = err_cyc_q.size(); b0 = busy_total;
    send_frame(8'hA5, 1'b1, s);
    idle(8);
    check("a5_count", rcv_cyc_q.size(), n0 + 1);
    check("a5_byte",  (rcv_cyc_q.size() > n0) ? {24'd0, rcv_byte_q[n0]} : 32'hFFFF_FFFF, 32'hA5);
    check("a5_time",  (rcv_cyc_q.size() > n0) ? rcv_cyc_q[n0] - s : -1, 41);
    check("a5_no_err", err_cyc_q.size(), e0);
    check("a5_busy_cycles", busy_total - b0, 38);

    // One-cycle glitch: START for HALF cycles, then back to IDLE
    n0 = rcv_cyc_q.size(); e0 = err_cyc_q.size(); b0 = busy_total;
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(10);
    check("glitch_no_rcv", rcv_cyc_q.size(), n0);
    check("glitch_no_err", err_cyc_q.size(), e0);
    check("glitch_busy_cycles", busy_total - b0, HALF);
    check("glitch_byte_held", {24'd0, rx_byte}, 32'hA5);

    // 0x3C with stop bit low, line held low 20 cycles from the stop bit
    n0 = rcv_cyc_q.size(); e0 = err_cyc_q.size(); b0 = busy_total;
    send_frame(8'h3C, 1'b0, s);
    idle(16);
    check("ferr_count", err_cyc_q.size(), e0 + 1);
    check("ferr_time",  (err_cyc_q.size() > e0) ? err_cyc_q[e0] - s : -1, 41);
    check("ferr_no_rcv", rcv_cyc_q.size(), n0);
    check("ferr_busy_cycles", busy_total - b0, 38);
    check("ferr_byte_held", {24'd0, rx_byte}, 32'hA5);
    rx = 1'b1;
    idle(6);
    n0 = rcv_cyc_q.size();
    send_frame(8'h3C, 1'b1, s);
    idle(8);
    check("3c_count", rcv_cyc_q.size(), n0 + 1);
    check("3c_byte",  {24'd0, rx_byte}, 32'h3C);

    // Back-to-back 0x00 then 0xFF
    n0 = rcv_cyc_q.size(); e0 = err_cyc_q.size();
    send_frame(8'h00, 1'b1, s);
    send_frame(8'hFF, 1'b1, s2);
    idle(8);
    check("b2b_count", rcv_cyc_q.size(), n0 + 2);
    check("b2b_byte0", (rcv_cyc_q.size() > n0)     ? {24'd0, rcv_byte_q[n0]}     : 32'hFFFF_FFFF, 32'h00);
    check("b2b_byte1", (rcv_cyc_q.size() > n0 + 1) ? {24'd0, rcv_byte_q[n0 + 1]} : 32'hFFFF_FFFF, 32'hFF);
    check("b2b_gap",   (rcv_cyc_q.size() > n0 + 1) ? rcv_cyc_q[n0 + 1] - rcv_cyc_q[n0] : -1, 40);
    check("b2b_start_gap", s2 - s, 40);
    check("b2b_no_err", err_cyc_q.size(), e0);

    // Reset during data bit 3 of 0x5A; transmitter abandons the frame too
    n0 = rcv_cyc_q.size(); e0 = err_cyc_q.size();
    v  = 8'h5A;
    rx = 1'b0;
    idle(CPB);
    for (int k = 0; k < 3; k++) begin
      rx = v[k];
      idle(CPB);
    end
    rx = v[3];
    idle(2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    rx    = 1'b1;
    idle(30);
    check("midrst_no_rcv", rcv_cyc_q.size(), n0);
    check("midrst_no_err", err_cyc_q.size(), e0);
    check("midrst_byte",   {24'd0, rx_byte}, 32'h00);
    send_frame(8'h81, 1'b1, s);
    idle(8);
    check("81_count", rcv_cyc_q.size(), n0 + 1);
    check("81_byte",  {24'd0, rx_byte}, 32'h81);

    // Line held low through reset and for 50 cycles afterwards
    n0 = rcv_cyc_q.size(); e0 = err_cyc_q.size();
    rx    = 1'b0;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    b0 = busy_total;
    idle(50);
    check("lowrst_no_rcv", rcv_cyc_q.size(), n0);
    check("lowrst_no_err", err_cyc_q.size(), e0);
    check("lowrst_busy_cycles", busy_total - b0, 0);
    check("lowrst_is_receiving", {31'd0, is_receiving}, 32'd0);
    rx = 1'b1;
    idle(6);
    send_frame(8'h42, 1'b1, s);
    idle(8);
    check("42_count", rcv_cyc_q.size(), n0 + 1);
    check("42_byte",  {24'd0, rx_byte}, 32'h42);
    check("42_time",  (rcv_cyc_q.size() > n0) ? rcv_cyc_q[n0] - s : -1, 41);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that turns an asynchronous 8N1 UART line into single-cycle byte strobes. It sits directly upstream of the command controller and drives that controller's `received` / `rx_byte` inputs. The line is resampled into the `clk` domain, start-bit glitches are rejected, and frames with a bad stop bit are flagged.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 104: clock cycles per bit (12 MHz / 115200). Must be ≥ 4.

Ports:
- `clk` in 1: system clock. One clock domain; every register is clocked on `posedge clk`.
- `reset` in 1: synchronous, active-high reset.
- `rx` in 1: raw asynchronous serial line. Idles high.
- `received` out 1: one-cycle pulse when a valid frame completes. Reset value 0.
- `rx_byte` out 8: last valid byte. Updated only together with `received`; holds otherwise. Reset value 0x00.
- `recv_error` out 1: one-cycle pulse on a framing error (stop bit low). Reset value 0.
- `is_receiving` out 1: high in START, DATA and STOP. Reset value 0.

## Operation
- Synchronizer: `rx` passes through two flops to give `rx_sync`. Both flops reset to 1. All decisions below use `rx_sync`.
- Derived constants:
  - HALF = CLKS_PER_BIT/2, floor division.
  - Counter `cnt` is $clog2(CLKS_PER_BIT) bits wide.
  - Bit index `bit_idx` is 3 bits.
  - Shift register `shreg` is 8 bits.
- State machine:
  - IDLE: if `rx_sync`==0, go to START with `cnt`=0.
  - START: `cnt` increments each cycle. At `cnt`==HALF-1:
    - `rx_sync`==0: go to DATA with `cnt`=0 and `bit_idx`=0.
    - `rx_sync`==1: glitch. Go to IDLE with no pulse.
  - DATA: `cnt` increments each cycle. At `cnt`==CLKS_PER_BIT-1:
    - shift LSB first: `shreg` <= {`rx_sync`, `shreg`[7:1]}; set `cnt`=0.
    - if `bit_idx`==7, go to STOP; otherwise increment `bit_idx`.
  - STOP: at `cnt`==CLKS_PER_BIT-1:
    - `rx_sync`==1: set `rx_byte` <= `shreg`, pulse `received`, go to IDLE.
    - `rx_sync`==0: pulse `recv_error`, go to WAIT_IDLE. `rx_byte` is unchanged.
  - WAIT_IDLE: stay until `rx_sync`==1, then go to IDLE. Emits no pulses.
- Reset:
  - State goes to WAIT_IDLE, not IDLE, so a line held low at or after reset never starts a frame.
  - Reset mid-frame abandons the frame with no pulse. `rx_byte` returns to 0x00.
- Pulses:
  - `received` and `recv_error` are registered, each high for exactly one cycle.
  - They are mutually exclusive.
- There is no flow control. The consumer must take `rx_byte` on the `received` cycle or later, before the next frame completes.

## Timing
- T0 is the first cycle in IDLE with `rx_sync`==0. This is 2–3 cycles after the falling edge on `rx`.
- Sample points, each taken at the clock edge ending that cycle:
  - start re-check: cycle T0+HALF
  - data bit k (k = 0..7): T0+HALF+(k+1)·CLKS_PER_BIT
  - stop bit: T0+HALF+9·CLKS_PER_BIT
- `received` or `recv_error` is high in cycle T0+HALF+9·CLKS_PER_BIT+1.
- `rx_byte` is valid in that same cycle.
- State is IDLE in the cycle after the stop sample, so the next falling edge can be detected immediately.
- Back-to-back frames with a single stop bit are supported.
- Tolerated baud mismatch is about ±4%, since every sample is taken mid-bit.
- `is_receiving` follows the registered state: high from T0+1 through the stop-sample cycle inclusive.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding (`UART_IDLE`, `UART_START`, `UART_DATA`, `UART_STOP`, `UART_WAIT_IDLE`);
  - the default `CLKS_PER_BIT` constant, so a future `uart_tx` matches it.
- One sub-module, `sync2`: a two-flop synchronizer with a reset value parameter, reused later for other async inputs.
- Everything else stays in a single sequential process.

## Test plan
All scenarios use CLKS_PER_BIT=4 (HALF=2) and drive `rx` one bit per 4 cycles.
- After reset, send 0xA5 → one `received` pulse in cycle T0+39; `rx_byte`=0xA5; no `recv_error`; `is_receiving` high T0+1..T0+38.
- Hold `rx` low for 1 cycle in IDLE, then high → no pulse; back in IDLE by T0+3; `rx_byte` unchanged.
- Send 0x3C with the stop bit low and hold low 20 cycles → `recv_error` pulse in cycle T0+39; no `received`; stays in WAIT_IDLE. Then release high and send 0x3C normally → `received` with `rx_byte`=0x3C.
- Send 0x00 then 0xFF back-to-back, one stop bit each → two `received` pulses 40 cycles apart with 0x00 then 0xFF.
- Assert `reset` for 1 cycle during data bit 3 of 0x5A → no pulse; `rx_byte`=0x00. The following 0x81 frame → `received`, `rx_byte`=0x81.
- Hold `rx` low through reset and for 50 cycles after → no pulses and `is_receiving`=0. Raise `rx`, then send 0x42 → `received`, `rx_byte`=0x42.
